clint_unit: RTL and testbench
=============================

Name: clint_unit

Overview:
- Core-local interruptor for the single-hart RV32 SoC, on the shared valid/ready memory bus behind the SoC address decoder.
- Receives address offsets; the decoder has already subtracted the CLINT base address.
- Holds the software-interrupt bit (msip), the 64-bit timer (mtime) and the 64-bit compare register (mtimecmp).
- Drives msip, mtip and mtime straight to the CPU.

Parameters:
- TICK_DIV, default 1: number of clock cycles per mtime increment. Legal range 1..65535. Value 1 means mtime increments every cycle.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- clint_valid  in  1  request strobe, one cycle per request
- clint_instr  in  1  instruction-fetch flag; ignored
- clint_addr  in  32  byte offset within the CLINT region
- clint_wdata  in  32  write data
- clint_wstrb  in  4  byte write enables; 0000 means read
- clint_rdata  out  32  read data, valid while clint_ready=1
- clint_ready  out  1  one-cycle response pulse
- clint_msip  out  1  machine software interrupt pending
- clint_mtip  out  1  machine timer interrupt pending
- clint_mtime  out  64  current mtime value

Behaviour:
- Interface timing: one clock (clock); reset is synchronous and active-high.
- Reset values:
  - msip = 0, mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, prescaler = 0.
  - clint_ready = 0, clint_rdata = 0, clint_mtip = 0.
- Register map (offset, word access, addr[1:0] ignored, decode on addr[15:2]):
  - 0x0000 msip: bit 0 is R/W, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other offset reads 0, ignores writes, and still responds.
- Handshake:
  - clint_valid=1 sampled at edge N gives clint_ready=1 for exactly one cycle after edge N (registered, latency 1).
  - For reads, clint_rdata holds the register value sampled at edge N. At all other times clint_ready=0 and clint_rdata=0.
  - Back-to-back requests on consecutive cycles are accepted and produce consecutive ready pulses.
  - No request queueing; valid is a single-cycle strobe.
- Writes: byte-merged per clint_wstrb into the addressed word at edge N. For msip, only bit 0 is stored, under wstrb[0]. Write responses return rdata=0.
- Timer:
  - Prescaler counts 0..TICK_DIV-1. mtime increments by 1 (64-bit, wraps from all-ones to 0) when the prescaler wraps.
  - With TICK_DIV=1, mtime increments every cycle.
  - A bus write to either mtime word overrides the increment for that cycle: the written bytes are taken as written, unwritten bytes keep their current values with no increment applied.
  - A write to the low word does not carry into the high word.
- Interrupts:
  - clint_mtip is registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit compare on current register values. It lags the compare by one cycle.
  - clint_msip = msip bit, registered.
  - clint_mtime = mtime register, combinational from the register.
- Simultaneous events: a read of mtime in the same cycle as an increment returns the pre-increment value.
- Reset mid-operation: a pending response is dropped (ready=0 in the cycle after reset) and all registers take their reset values.

Test Plan:
- Reset then idle 10 cycles (TICK_DIV=1) -> mtime=10 ±1 per count convention; mtip=0; msip=0; ready never asserted.
- Write 0x1 to 0x0000 with wstrb=1111 -> ready pulse next cycle; msip=1. Read 0x0000 -> rdata=0x00000001. Write 0 -> msip=0.
- Write mtimecmp: hi=0, lo=0x20 -> mtip goes 1 one cycle after mtime reaches 0x20. Rewrite hi=0xFFFFFFFF -> mtip=0.
- Write mtime lo=0xFFFFFFFF, hi=0 -> mtime passes 0x0000_0000_FFFF_FFFF then 0x0000_0001_0000_0000 (carry across words). Read 0xBFFC -> 0x00000001.
- Read unmapped offset 0x1234 -> ready=1, rdata=0. Byte write wstrb=0010, data 0x0000AB00 to 0x4000 -> only mtimecmp[15:8]=0xAB changes.
- Assert reset while a request is in flight -> ready=0 next cycle; mtime=0; mtimecmp all-ones; mtip=0.

Source files
------------

// File: rtl/clint_unit.sv
// Core-local interruptor: msip, 64-bit mtime with prescaler, 64-bit mtimecmp,
// exposed on the single-cycle valid/ready memory bus and wired to the hart.
module clint_unit #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    // Word offsets (byte offset >> 2) inside the CLINT region.
    localparam logic [13:0] A_MSIP    = 14'h0000;
    localparam logic [13:0] A_CMP_LO  = 14'h1000;
    localparam logic [13:0] A_CMP_HI  = 14'h1001;
    localparam logic [13:0] A_TIME_LO = 14'h2FFE;
    localparam logic [13:0] A_TIME_HI = 14'h2FFF;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic        msip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] prescaler;

    logic        tick;
    logic        wr_en;
    logic        rd_en;
    logic [13:0] word;
    logic [31:0] read_val;
    logic [63:0] mtime_next;
    logic        unused_bits;

    assign unused_bits = ^{clint_instr, clint_addr[31:16], clint_addr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Handshake: clint_valid is a one-cycle strobe; every strobe sampled at an
    // edge yields exactly one clint_ready pulse in the following cycle, with
    // clint_rdata carrying read data for reads and 0 otherwise (and 0 when idle).
    always_comb begin
        word     = clint_addr[15:2];
        wr_en    = clint_valid && (clint_wstrb != 4'b0000);
        rd_en    = clint_valid && (clint_wstrb == 4'b0000);
        tick     = (prescaler == TICK_LAST);
        read_val = 32'h0;
        case (word)
            A_MSIP:    read_val = {31'h0, msip};
            A_CMP_LO:  read_val = mtimecmp[31:0];
            A_CMP_HI:  read_val = mtimecmp[63:32];
            A_TIME_LO: read_val = mtime[31:0];
            A_TIME_HI: read_val = mtime[63:32];
            default:   read_val = 32'h0;
        endcase

        // A bus write to either mtime word replaces the increment for that cycle.
        mtime_next = tick ? mtime + 64'd1 : mtime;
        if (wr_en && word == A_TIME_LO) begin
            mtime_next = {mtime[63:32], merge(mtime[31:0], clint_wdata, clint_wstrb)};
        end else if (wr_en && word == A_TIME_HI) begin
            mtime_next = {merge(mtime[63:32], clint_wdata, clint_wstrb), mtime[31:0]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            msip        <= 1'b0;
            mtime       <= 64'h0;
            mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescaler   <= 16'h0;
            clint_ready <= 1'b0;
            clint_rdata <= 32'h0;
            clint_mtip  <= 1'b0;
        end else begin
            prescaler   <= tick ? 16'h0 : prescaler + 16'd1;
            mtime       <= mtime_next;
            clint_ready <= clint_valid;
            clint_rdata <= rd_en ? read_val : 32'h0;
            clint_mtip  <= (mtime >= mtimecmp);
            if (wr_en) begin
                case (word)
                    A_MSIP:   if (clint_wstrb[0]) msip <= clint_wdata[0];
                    A_CMP_LO: mtimecmp[31:0]  <= merge(mtimecmp[31:0], clint_wdata, clint_wstrb);
                    A_CMP_HI: mtimecmp[63:32] <= merge(mtimecmp[63:32], clint_wdata, clint_wstrb);
                    default:  ;
                endcase
            end
        end
    end

    assign clint_msip  = msip;
    assign clint_mtime = mtime;

endmodule

// File: tb/tb_clint_unit.sv
// Directed bench for clint_unit (TICK_DIV=1): bus responses go through an
// expected-data queue, timer/interrupt outputs are checked against cycle counts.
module tb_clint_unit;

    logic        clock;
    logic        reset;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    int          checks   = 0;
    int          failures = 0;
    int          now      = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_data;

    clint_unit #(.TICK_DIV(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .clint_valid (clint_valid),
        .clint_instr (clint_instr),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        now++;
    endtask

    // Driver: one-cycle strobe; the expected rdata is queued when driven.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp);
        clint_valid = 1'b1;
        clint_addr  = addr;
        clint_wdata = wdata;
        clint_wstrb = wstrb;
        exp_q.push_back(exp);
        step();
        check("ready_pulse", 64'(clint_ready), 64'd1);
        clint_valid = 1'b0;
        clint_addr  = 32'h0;
        clint_wdata = 32'h0;
        clint_wstrb = 4'h0;
    endtask

    // Scoreboard: every ready pulse pops one expectation; idle rdata must be 0.
    always @(negedge clock) begin
        if (clint_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(clint_ready), 64'd0);
            end else begin
                exp_data = exp_q.pop_front();
                check("rdata", 64'(clint_rdata), 64'(exp_data));
            end
        end else begin
            check("idle_rdata", 64'(clint_rdata), 64'd0);
        end
    end

    initial begin
        reset       = 1'b1;
        clint_valid = 1'b0;
        clint_instr = 1'b0;
        clint_addr  = 32'h0;
        clint_wdata = 32'h0;
        clint_wstrb = 4'h0;
        repeat (3) step();
        check("rst_ready", 64'(clint_ready), 64'd0);
        check("rst_mtime", clint_mtime, 64'd0);
        check("rst_mtip", 64'(clint_mtip), 64'd0);
        check("rst_msip", 64'(clint_msip), 64'd0);

        // Idle counting
        reset = 1'b0;
        now   = 0;
        repeat (10) step();
        check("idle_mtime", clint_mtime, 64'd10);
        check("idle_mtip", 64'(clint_mtip), 64'd0);
        check("idle_msip", 64'(clint_msip), 64'd0);

        // msip
        bus(32'h0000, 32'h1, 4'hF, 32'h0);
        check("msip_set", 64'(clint_msip), 64'd1);
        bus(32'h0000, 32'h0, 4'h0, 32'h1);
        bus(32'h0000, 32'h0, 4'hF, 32'h0);
        check("msip_clr", 64'(clint_msip), 64'd0);
        bus(32'h0000, 32'hFFFF_FFFF, 4'b1110, 32'h0);
        check("msip_strb", 64'(clint_msip), 64'd0);

        // mtimecmp = 0x20: mtip rises one cycle after mtime reaches it
        bus(32'h4004, 32'h0, 4'hF, 32'h0);
        bus(32'h4000, 32'h20, 4'hF, 32'h0);
        check("cmp_mtime", clint_mtime, 64'(now));
        check("cmp_mtip_before", 64'(clint_mtip), 64'd0);
        while (now < 32) step();
        check("cmp_mtime_eq", clint_mtime, 64'h20);
        check("cmp_mtip_lag", 64'(clint_mtip), 64'd0);
        step();
        check("cmp_mtip_set", 64'(clint_mtip), 64'd1);
        bus(32'hBFF8, 32'h0, 4'h0, 32'(now));
        bus(32'h4004, 32'hFFFF_FFFF, 4'hF, 32'h0);
        check("cmp_mtip_hold", 64'(clint_mtip), 64'd1);
        step();
        check("cmp_mtip_clr", 64'(clint_mtip), 64'd0);

        // mtime writes and carry across words
        bus(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0);
        bus(32'hBFFC, 32'h0, 4'hF, 32'h0);
        check("time_wr", clint_mtime, 64'h0000_0000_FFFF_FFFF);
        step();
        check("time_carry", clint_mtime, 64'h0000_0001_0000_0000);
        bus(32'hBFFC, 32'h0, 4'h0, 32'h1);
        bus(32'hBFF8, 32'h0, 4'h0, 32'h1);
        check("time_after_rd", clint_mtime, 64'h0000_0001_0000_0002);

        // 64-bit wrap
        bus(32'hBFF8, 32'hFFFF_FFFE, 4'hF, 32'h0);
        bus(32'hBFFC, 32'hFFFF_FFFF, 4'hF, 32'h0);
        check("wrap_pre", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("wrap_ones", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("wrap_zero", clint_mtime, 64'h0);

        // Unmapped offsets and byte write to mtimecmp low
        bus(32'h1234, 32'h0, 4'h0, 32'h0);
        bus(32'h1234, 32'hDEAD_BEEF, 4'hF, 32'h0);
        bus(32'h4000, 32'h0000_AB00, 4'b0010, 32'h0);
        bus(32'h4000, 32'h0, 4'h0, 32'h0000_AB20);
        bus(32'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF);

        // Reset while a request is in flight
        clint_valid = 1'b1;
        clint_addr  = 32'hBFF8;
        clint_wstrb = 4'h0;
        reset       = 1'b1;
        step();
        clint_valid = 1'b0;
        check("rst_fl_ready", 64'(clint_ready), 64'd0);
        check("rst_fl_mtime", clint_mtime, 64'd0);
        check("rst_fl_mtip", 64'(clint_mtip), 64'd0);
        reset = 1'b0;
        bus(32'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF);
        bus(32'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF);
        step();
        check("rst_fl_mtip2", 64'(clint_mtip), 64'd0);

        step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
